// File: rtl/fsgnj_if.sv
// fsgnj_if: handshake, operand and result bundle for the sign-injection pipeline
interface fsgnj_if #(
  parameter int FLEN = 32,
  parameter int TAGW = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [FLEN-1:0] x1;
  logic [FLEN-1:0] x2;
  logic [1:0]      mode;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [FLEN-1:0] y;
  logic [TAGW-1:0] out_tag;
  logic            out_illegal;
  logic            busy;
  modport master (
    output flush, in_valid, x1, x2, mode, in_tag, out_ready,
    input  in_ready, out_valid, y, out_tag, out_illegal, busy
  );
  modport slave (
    input  flush, in_valid, x1, x2, mode, in_tag, out_ready,
    output in_ready, out_valid, y, out_tag, out_illegal, busy
  );
endinterface

// File: rtl/fsgnj_pipe.sv
// fsgnj_pipe: pipelined FSGNJ/FSGNJN/FSGNJX unit with elastic valid/ready handshake and flush
module fsgnj_pipe #(
  parameter int FLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAGW   = 5
) (
  input logic    clk,
  input logic    rst,
  fsgnj_if.slave io
);
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ill_q;
  logic [STAGES-1:0] adv;
  logic [FLEN-1:0]   dat_q [STAGES];
  logic [TAGW-1:0]   tag_q [STAGES];
  logic              sgn_d;
  logic [FLEN-1:0]   res_d;
  always_comb begin
    sgn_d = io.mode == 2'b00 ? io.x2[FLEN-1] :
            io.mode == 2'b01 ? ~io.x2[FLEN-1] :
            io.mode == 2'b10 ? io.x1[FLEN-1] ^ io.x2[FLEN-1] : io.x1[FLEN-1];
    res_d = {sgn_d, io.x1[FLEN-2:0]};
  end
  // a stage may advance if it or any stage downstream holds a bubble, or the output drains
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    assign adv[i] = io.out_ready | ~&vld_q[STAGES-1:i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ill_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        dat_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        vld_q[0] <= io.in_valid;
        dat_q[0] <= res_d;
        tag_q[0] <= io.in_tag;
        ill_q[0] <= &io.mode;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= dat_q[i-1];
          tag_q[i] <= tag_q[i-1];
          ill_q[i] <= ill_q[i-1];
        end
      end
      if (io.flush) vld_q <= '0;
    end
  end
  assign io.in_ready    = adv[0];
  assign io.out_valid   = vld_q[STAGES-1];
  assign io.y           = dat_q[STAGES-1];
  assign io.out_tag     = tag_q[STAGES-1];
  assign io.out_illegal = ill_q[STAGES-1];
  assign io.busy        = |vld_q;
endmodule

// File: tb/tb_fsgnj_pipe.sv
// tb_fsgnj_pipe: directed checks of a single-stage 32-bit and a three-stage 64-bit sign-injection pipe
module tb_fsgnj_pipe;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fsgnj_if #(.FLEN(32), .TAGW(5)) ia ();
  fsgnj_if #(.FLEN(64), .TAGW(5)) ib ();
  fsgnj_pipe #(.FLEN(32), .STAGES(1), .TAGW(5)) ua (.clk(clk), .rst(rst), .io(ia));
  fsgnj_pipe #(.FLEN(64), .STAGES(3), .TAGW(5)) ub (.clk(clk), .rst(rst), .io(ib));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_a(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    ia.in_valid = 1'b1;
    ia.mode = md;
    ia.x1 = a;
    ia.x2 = b;
    ia.in_tag = t;
    tick();
    ia.in_valid = 1'b0;
  endtask
  initial begin
    int acc, first_block, got, first, last;
    logic exp_ov;
    rst = 1'b1;
    {ia.flush, ia.in_valid, ia.x1, ia.x2, ia.mode, ia.in_tag} = '0;
    {ib.flush, ib.in_valid, ib.x1, ib.x2, ib.mode, ib.in_tag} = '0;
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_a_ov", ia.out_valid, 0);
    chk("rst_a_y", ia.y, 0);
    chk("rst_a_busy", ia.busy, 0);
    chk("rst_a_rdy", ia.in_ready, 1);
    chk("rst_b_ov", ib.out_valid, 0);
    chk("rst_b_tag", ib.out_tag, 0);
    chk("rst_b_ill", ib.out_illegal, 0);
    chk("rst_b_rdy", ib.in_ready, 1);
    send_a(2'b00, 32'h3F800000, 32'h80000000, 5'd3);
    chk("a_j_ov", ia.out_valid, 1);
    chk("a_j_y", ia.y, 64'hBF800000);
    chk("a_j_tag", ia.out_tag, 3);
    chk("a_j_ill", ia.out_illegal, 0);
    send_a(2'b01, 32'hBF800000, 32'hBF800000, 5'd4);
    chk("a_jn_y", ia.y, 64'h3F800000);
    chk("a_jn_tag", ia.out_tag, 4);
    send_a(2'b10, 32'hC0000000, 32'h80000000, 5'd5);
    chk("a_jx_y", ia.y, 64'h40000000);
    chk("a_jx_ill", ia.out_illegal, 0);
    send_a(2'b11, 32'h7FC00001, 32'h80000000, 5'd6);
    chk("a_ill_y", ia.y, 64'h7FC00001);
    chk("a_ill_flag", ia.out_illegal, 1);
    send_a(2'b00, 32'h7F800001, 32'h00000000, 5'd7);
    chk("a_nan_y", ia.y, 64'h7F800001);
    tick();
    chk("a_idle_ov", ia.out_valid, 0);
    for (int c = 0; c < 10; c++) begin
      ib.in_valid = c < 6;
      ib.in_tag = 5'(c + 1);
      ib.mode = 2'b01;
      ib.x1 = 64'h7FF0000000000001;
      ib.x2 = 64'h0;
      tick();
      exp_ov = c >= 2 && c < 8;
      chk("b_lat_ov", ib.out_valid, exp_ov);
      if (exp_ov) begin
        chk("b_lat_tag", ib.out_tag, c - 1);
        chk("b_jn_y", ib.y, 64'hFFF0000000000001);
      end
    end
    ib.in_valid = 1'b0;
    ib.out_ready = 1'b0;
    acc = 0;
    first_block = -1;
    for (int c = 0; c < 6; c++) begin
      ib.in_valid = 1'b1;
      ib.in_tag = 5'(10 + acc);
      ib.mode = 2'b00;
      ib.x1 = 64'h4000000000000000 | 64'(10 + acc);
      ib.x2 = 64'h8000000000000000;
      if (!ib.in_ready && first_block < 0) first_block = acc;
      if (ib.in_ready) acc++;
      tick();
      if (ib.out_valid) begin
        chk("stall_y", ib.y, 64'hC00000000000000A);
        chk("stall_tag", ib.out_tag, 10);
      end
    end
    ib.in_valid = 1'b0;
    chk("stall_acc", acc, 3);
    chk("stall_block", first_block, 3);
    chk("stall_rdy", ib.in_ready, 0);
    ib.out_ready = 1'b1;
    got = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 8; k++) begin
      if (ib.out_valid) begin
        chk("rel_tag", ib.out_tag, 10 + got);
        chk("rel_y", ib.y, 64'hC000000000000000 | 64'(10 + got));
        if (first < 0) first = k;
        last = k;
        got++;
      end
      tick();
    end
    chk("rel_cnt", got, 3);
    chk("rel_span", last - first, 2);
    for (int c = 0; c < 3; c++) begin
      ib.in_valid = 1'b1;
      ib.in_tag = 5'(20 + c);
      ib.x1 = 64'h1234;
      ib.flush = c == 2;
      if (c == 2) chk("fl_pre_busy", ib.busy, 1);
      tick();
    end
    ib.flush = 1'b0;
    ib.in_valid = 1'b0;
    chk("fl_busy", ib.busy, 0);
    chk("fl_ov", ib.out_valid, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("fl_later_ov", ib.out_valid, 0);
    end
    ib.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ib.in_valid = 1'b1;
      ib.in_tag = 5'(30 + c);
      ib.mode = 2'b11;
      ib.x1 = 64'h5555000000000001;
      tick();
    end
    ib.in_valid = 1'b0;
    chk("mr_pre_ov", ib.out_valid, 1);
    chk("mr_pre_ill", ib.out_illegal, 1);
    chk("mr_pre_rdy", ib.in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ov", ib.out_valid, 0);
    chk("mr_y", ib.y, 0);
    chk("mr_tag", ib.out_tag, 0);
    chk("mr_ill", ib.out_illegal, 0);
    chk("mr_busy", ib.busy, 0);
    chk("mr_rdy", ib.in_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsgnj_pipe.md
Name: fsgnj_pipe

Overview:
- Parametrised, pipelined floating-point sign-injection unit for the FPU execute stage.
- Covers the full RISC-V FSGNJ family: FSGNJ, FSGNJN and FSGNJX. FMV/FNEG/FABS are reached through operand choice.
- Generalised in operand width (single/double) and in pipeline depth.
- Uses a valid/ready elastic handshake with a tag pass-through and a flush, so it can sit alongside multi-cycle FPU units.

Parameters:
- FLEN, 32, operand width in bits (32 or 64). The sign bit is bit FLEN-1.
- STAGES, 1, number of register stages (1..4). Latency is STAGES cycles when there is no stall.
- TAGW, 5, width of the tag (destination register id) carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an input this cycle.
- x1  in  FLEN  magnitude/exponent source operand.
- x2  in  FLEN  sign source operand.
- mode  in  2  operation select: 00 J, 01 JN, 10 JX, 11 illegal.
- in_tag  in  TAGW  tag for the operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- y  out  FLEN  result.
- out_tag  out  TAGW  tag of the result.
- out_illegal  out  1  result came from mode 11.
- busy  out  1  at least one stage holds a valid operation.

Behaviour:
- Result function, computed combinationally at input and registered into stage 0:
  - J: y = {x2[FLEN-1], x1[FLEN-2:0]}
  - JN: y = {~x2[FLEN-1], x1[FLEN-2:0]}
  - JX: y = {x1[FLEN-1] ^ x2[FLEN-1], x1[FLEN-2:0]}
  - 11: y = x1 unchanged, with out_illegal=1 for that operation.
- No NaN canonicalisation: NaN payloads and signalling bits pass through untouched.
- Pipeline state:
  - STAGES registers. Each holds {valid, data[FLEN], tag[TAGW], illegal}.
  - Stage STAGES-1 drives y, out_tag, out_illegal and out_valid.
- Advance rule:
  - adv[STAGES-1] = ~valid[STAGES-1] | out_ready.
  - adv[i] = ~valid[i] | adv[i+1] for i < STAGES-1.
  - in_ready = adv[0]. This is combinational from out_ready; it is an intentional ready chain with no skid buffer.
- Transfer:
  - An input is accepted when in_valid & in_ready.
  - When adv[i] is true, stage i loads stage i-1 (or the input for stage 0), including its valid bit.
  - A stage with adv false holds its contents.
- Latency and throughput:
  - A transfer accepted in cycle N produces out_valid in cycle N+STAGES if the pipeline does not stall.
  - Throughput is one operation per cycle.
- Stall:
  - When out_ready=0 and out_valid=1, y, out_tag and out_illegal stay stable until accepted.
  - Bubbles ahead of the stalled stage continue to collapse.
  - in_ready drops only when every stage is valid and the output is stalled.
- Reset (rst=1):
  - All valid bits clear. Data, tag and illegal registers clear to 0.
  - Outputs after reset: out_valid=0, y=0, out_tag=0, out_illegal=0, busy=0.
  - in_ready becomes 1 in the first cycle after reset.
  - rst takes priority over flush and over any transfer.
- Flush (flush=1):
  - All valid bits clear at the next edge. Data registers may keep stale values.
  - An input presented in the same cycle as flush is dropped, even if in_ready=1.
  - Output handshake in the flush cycle: if out_valid & out_ready, the transfer counts as completed. Otherwise the result is lost.
- busy = OR of all valid bits.
- Width rule: FLEN=64 uses bit 63 as the sign bit. No NaN-boxing of 32-bit values is done inside this block.

Test Plan:
- FLEN=32, STAGES=1: mode J with x1=0x3F800000, x2=0x80000000, tag=3, out_ready=1 -> next cycle y=0xBF800000, out_tag=3, out_illegal=0. Mode JN with x1=x2=0xBF800000 -> y=0x3F800000.
- Mode JX with x1=0xC0000000, x2=0x80000000 -> y=0x40000000 (fabs form). Mode 11 with x1=0x7FC00001 -> y=0x7FC00001, out_illegal=1.
- FLEN=64, STAGES=3: back-to-back inputs with tags 1..6, out_ready=1 -> out_valid first asserted 3 cycles after the first accept; tags emerge 1..6 on consecutive cycles. JN with x1=0x7FF0000000000001 -> y=0xFFF0000000000001.
- STAGES=3 stall: hold out_ready=0 while streaming -> in_ready falls after exactly 3 accepts; y is stable throughout. Release out_ready -> exactly one result per cycle, none lost or duplicated.
- Flush with 2 operations in flight plus an input in the same cycle -> next cycle busy=0, out_valid=0. None of the 3 operations ever appear at the output.
- Reset mid-stream with 3 valid stages and out_ready=0 -> next cycle out_valid=0, y=0, out_tag=0, busy=0, in_ready=1.
